// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: walks WIDTH operand bits LSB first through a 1-bit slice with a carry/shift flop.
// Optional zero flag output is enabled by defining BSALU_ZERO_FLAG_EN.
module bit_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [2:0]       opsel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             c_flag
`ifdef BSALU_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic [2:0]       opsel_q, opsel_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             c_flag_q, c_flag_d;
`ifdef BSALU_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    // Single-bit slice outputs for the current bit index.
    logic a_bit, b_bit, x_bit, res_bit, carry_nx, cout_fin, carry_init;

    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        a_bit    = a_q[idx_q];
        b_bit    = b_q[idx_q];
        x_bit    = 1'b0;
        res_bit  = 1'b0;
        carry_nx = carry_q;
        cout_fin = 1'b0;
        if (!mode_q) begin
            case (opsel_q)
                3'b000, 3'b110: x_bit = b_bit;
                3'b001, 3'b011: x_bit = ~b_bit;
                3'b101:         x_bit = 1'b1;
                default:        x_bit = 1'b0;
            endcase
            if (opsel_q == 3'b010 || opsel_q == 3'b111) begin
                res_bit = a_bit;
            end else begin
                res_bit  = a_bit ^ x_bit ^ carry_q;
                carry_nx = (a_bit & x_bit) | (carry_q & (a_bit ^ x_bit));
                cout_fin = carry_nx;
            end
        end else begin
            case (opsel_q)
                3'b000: res_bit = a_bit & b_bit;
                3'b001: res_bit = a_bit | b_bit;
                3'b010: res_bit = a_bit ^ b_bit;
                3'b011: res_bit = ~a_bit;
                3'b101: begin
                    // Carry flop carries the previous A bit into this position.
                    res_bit  = carry_q;
                    carry_nx = a_bit;
                    cout_fin = a_bit;
                end
                default: res_bit = 1'b0;
            endcase
        end
    end

    // Carry flop seed, chosen from the live inputs at the accepting edge.
    always_comb begin
        carry_init = 1'b0;
        if (!mode) begin
            case (opsel)
                3'b001:                 carry_init = c_flag_q;
                3'b011, 3'b100, 3'b110: carry_init = 1'b1;
                default:                carry_init = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        opsel_d  = opsel_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sr_d     = sr_q;
        result_d = result_q;
        cout_d   = cout_q;
        c_flag_d = c_flag_q;
`ifdef BSALU_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    opsel_d = opsel;
                    idx_d   = '0;
                    carry_d = carry_init;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sr_d    = {res_bit, sr_q[WIDTH-1:1]};
                carry_d = carry_nx;
                if (idx_q == LAST_IDX) begin
                    state_d  = S_DONE;
                    result_d = sr_d;
                    cout_d   = cout_fin;
                    if (!mode_q) c_flag_d = cout_fin;
`ifdef BSALU_ZERO_FLAG_EN
                    zero_d   = (sr_d == '0);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; all of them, including the shadow
    // operands, are reset so a mid-operation reset leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            opsel_q  <= 3'b000;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sr_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            c_flag_q <= 1'b0;
`ifdef BSALU_ZERO_FLAG_EN
            zero_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            opsel_q  <= opsel_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            c_flag_q <= c_flag_d;
`ifdef BSALU_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign c_flag = c_flag_q;
`ifdef BSALU_ZERO_FLAG_EN
    assign zero   = zero_q;
`endif

endmodule
